// File: rtl/trig_primitive_tx.sv
// Trigger-link transmitter: per-channel primitive pulses, active-low ready line,
// accept/busy/readout FSM and link counters. Define TRIG_TIMESTAMP_EN for accept timestamps.
module trig_primitive_tx #(
    parameter int NCH = 15,
    parameter int CW  = 32,
    parameter int TSW = 48
) (
    input  logic             clk_adc,
    input  logic             reset,
    input  logic [NCH-1:0]   hit_in,
    input  logic [NCH-1:0]   chan_mask,
    input  logic [7:0]       pulse_len,
    input  logic [7:0]       holdoff,
    input  logic             trig_accept,
    input  logic             readout_done,
    input  logic [15:0]      busy_timeout,
    output logic [NCH-1:0]   coax_out_n,
    output logic             ready_n,
    output logic [1:0]       state_out,
    output logic [CW-1:0]    n_accepted,
    output logic [CW-1:0]    n_primitives,
    output logic [CW-1:0]    n_timeouts,
    output logic [TSW-1:0]   trig_timestamp
);

    localparam int PCW = $clog2(NCH + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCEPT   = 2'd1,
        ST_BUSY     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

    function automatic logic [PCW-1:0] popcount(input logic [NCH-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < NCH; i++) begin
            c = c + {{(PCW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == {CW{1'b1}}) ? x : x + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    logic [NCH-1:0] hit_q, hit_prev_q;
    logic           acc_q, acc_prev_q;
    logic [8:0]     tmr_q [NCH];
    logic [8:0]     tmr_d [NCH];
    logic [NCH-1:0] coax_q, coax_d;
    logic [NCH-1:0] load_s;
    logic [NCH-1:0] hit_rise_s;
    logic           acc_rise_s;
    logic           ready_n_q, ready_n_d;
    state_t         state_q, state_d;
    logic [15:0]    busy_cnt_q, busy_cnt_d;
    logic [CW-1:0]  n_acc_q, n_acc_d;
    logic [CW-1:0]  n_prim_q, n_prim_d;
    logic [CW-1:0]  n_tmo_q, n_tmo_d;
    logic [CW:0]    prim_sum_s;

    assign hit_rise_s = hit_q & ~hit_prev_q;
    assign acc_rise_s = acc_q & ~acc_prev_q;

    // Per-channel non-retriggerable timer: pulse phase while above holdoff, then dead time.
    always_comb begin
        load_s = '0;
        coax_d = '1;
        tmr_d  = tmr_q;
        for (int k = 0; k < NCH; k++) begin
            load_s[k] = hit_rise_s[k] & chan_mask[k] & (tmr_q[k] == 9'd0) & (pulse_len != 8'd0);
            if (load_s[k]) begin
                tmr_d[k] = {1'b0, pulse_len} + {1'b0, holdoff};
            end else if (tmr_q[k] != 9'd0) begin
                tmr_d[k] = tmr_q[k] - 9'd1;
            end else begin
                tmr_d[k] = tmr_q[k];
            end
            coax_d[k] = ~(tmr_q[k] > {1'b0, holdoff});
        end
    end

    // Saturating count of primitives launched this tick.
    always_comb begin
        prim_sum_s = {1'b0, n_prim_q} + {{(CW+1-PCW){1'b0}}, popcount(load_s)};
        if (prim_sum_s[CW]) begin
            n_prim_d = {CW{1'b1}};
        end else begin
            n_prim_d = prim_sum_s[CW-1:0];
        end
    end

    // Accept/busy FSM next-state and monitoring counters.
    always_comb begin
        state_d    = state_q;
        busy_cnt_d = busy_cnt_q;
        n_acc_d    = n_acc_q;
        n_tmo_d    = n_tmo_q;
        ready_n_d  = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (acc_rise_s) begin
                    state_d = ST_ACCEPT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                n_acc_d    = sat_inc(n_acc_q);
                busy_cnt_d = 16'd0;
                state_d    = ST_BUSY;
            end
            ST_BUSY: begin
                busy_cnt_d = busy_cnt_q + 16'd1;
                // readout_done wins over a coincident timeout
                if (readout_done) begin
                    state_d = ST_WAIT_LOW;
                end else if ((busy_timeout != 16'd0) && (busy_cnt_q == busy_timeout - 16'd1)) begin
                    state_d = ST_WAIT_LOW;
                    n_tmo_d = sat_inc(n_tmo_q);
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_WAIT_LOW: begin
                if (!acc_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LOW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, input pipeline and output registers.
    always_ff @(posedge clk_adc) begin
        if (reset) begin
            hit_q      <= '0;
            hit_prev_q <= '0;
            acc_q      <= 1'b0;
            acc_prev_q <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                tmr_q[k] <= 9'd0;
            end
            coax_q     <= '1;
            ready_n_q  <= 1'b1;
            state_q    <= ST_IDLE;
            busy_cnt_q <= 16'd0;
            n_acc_q    <= '0;
            n_prim_q   <= '0;
            n_tmo_q    <= '0;
        end else begin
            hit_q      <= hit_in;
            hit_prev_q <= hit_q;
            acc_q      <= trig_accept;
            acc_prev_q <= acc_q;
            for (int k = 0; k < NCH; k++) begin
                tmr_q[k] <= tmr_d[k];
            end
            coax_q     <= coax_d;
            ready_n_q  <= ready_n_d;
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            n_acc_q    <= n_acc_d;
            n_prim_q   <= n_prim_d;
            n_tmo_q    <= n_tmo_d;
        end
    end

`ifdef TRIG_TIMESTAMP_EN
    logic [TSW-1:0] ts_cnt_q;
    logic [TSW-1:0] trig_ts_q;

    // Free-running time base, sampled during the ACCEPT tick.
    always_ff @(posedge clk_adc) begin
        if (reset) begin
            ts_cnt_q  <= '0;
            trig_ts_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + {{(TSW-1){1'b0}}, 1'b1};
            if (state_q == ST_ACCEPT) begin
                trig_ts_q <= ts_cnt_q;
            end else begin
                trig_ts_q <= trig_ts_q;
            end
        end
    end

    assign trig_timestamp = trig_ts_q;
`else
    assign trig_timestamp = '0;
`endif

    assign coax_out_n   = coax_q;
    assign ready_n      = ready_n_q;
    assign state_out    = state_q;
    assign n_accepted   = n_acc_q;
    assign n_primitives = n_prim_q;
    assign n_timeouts   = n_tmo_q;

endmodule
